grid_mem_arbiter: RTL



---
 rtl/grid_pkg.sv | 37 +++
 rtl/grid_mem_arbiter_rr_picker.sv | 31 +++
 rtl/grid_mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the Tetris grid subsystem: geometry, cell codes,
// requester identities and the grid memory arbiter state encoding.
package grid_pkg;

  localparam int GRID_ADDR_W = 8;
  localparam int GRID_DATA_W = 8;

  // Cell contents stored in the grid RAM.
  typedef enum logic [GRID_DATA_W-1:0] {
    BLOCK_AIR    = 8'd0,
    BLOCK_I      = 8'd1,
    BLOCK_O      = 8'd2,
    BLOCK_T      = 8'd3,
    BLOCK_S      = 8'd4,
    BLOCK_Z      = 8'd5,
    BLOCK_J      = 8'd6,
    BLOCK_L      = 8'd7,
    BLOCK_BORDER = 8'd8
  } block_t;

  localparam int REQ_GAME    = 0;
  localparam int REQ_PLACER  = 1;
  localparam int REQ_CLEAR   = 2;
  localparam int REQ_DISPLAY = 3;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Round-robin successor of requester k among n requesters.
  function automatic logic [2:0] rr_next(input logic [2:0] k, input int n);
    return (int'(k) == n - 1) ? 3'd0 : k + 3'd1;
  endfunction

endpackage

// File: rtl/grid_mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping around, returned both one-hot and as an index.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [2:0]         pick_idx,
  output logic               any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the search so no path through
    // the loop leaves a value unassigned, which would infer a latch.
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    j        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      j = (int'(ptr) + off) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = 3'(j);
      end
    end
  end

endmodule

// File: rtl/grid_mem_arbiter.sv
// Round-robin arbiter sharing the single-port grid RAM among the grid clients,
// with lock-protected atomic sequences and hold-time preemption.
module grid_mem_arbiter
  import grid_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = GRID_ADDR_W,
  parameter int DATA_W   = GRID_DATA_W,
  parameter int MAX_HOLD = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        en,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [2:0]                owner
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [NUM_REQ-1:0]  pick;
  logic [2:0]          pick_idx;
  logic                pick_any;

  logic                granted;
  logic                own_req;
  logic                own_lock;
  logic                others_waiting;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // gnt is one-hot or zero, so masking with it selects the owner's bit.
  assign granted        = |gnt;
  assign own_req        = |(req & gnt);
  assign own_lock       = |(lock & gnt);
  assign others_waiting = |(req & ~gnt);

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(idx_q) == i) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the owner reaches the RAM; nothing is written while reset is applied.
  assign mem_addr  = granted ? sel_addr  : '0;
  assign mem_wdata = granted ? sel_wdata : '0;
  assign mem_we    = |(gnt & en & we) & ~reset;
  assign owner     = granted ? idx_q : 3'd0;
  assign rdata     = mem_rdata;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          idx_d   = pick_idx;
          hold_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        // hold_q counts earlier grant cycles, so HOLD_MAX marks the last allowed one.
        if (!own_req || (hold_q == HOLD_MAX && !own_lock && others_waiting)) begin
          gnt_d   = '0;
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        ptr_d   = rr_next(idx_q, NUM_REQ);
        hold_d  = '0;
        state_d = ARB_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // NOTE: reset is sampled on clk only; it is deliberately absent from the
  // sensitivity list so the whole block is a synchronous-reset register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt     <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      rvalid  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      gnt     <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      rvalid  <= gnt & en & ~we;
    end
  end

endmodule
